cmd_assembler: RTL and testbench
================================

# cmd_assembler

Byte-to-command front end between the Bluetooth UART transceiver and the command processor. Assembles pairs of received bytes (high byte first) into 16-bit commands, holds each command with a ready flag until the command processor consumes it, and returns an acknowledge byte over the UART transmitter whenever the command processor requests a response. An inter-byte timeout resynchronizes the byte pairing after a lost or corrupted byte.

## Interface
Parameters:
- TIMEOUT, default 22'd2_500_000: cycles allowed between high and low byte (50 ms at 50 MHz); must be ≥ 2.
- RESP_BYTE, default 8'hA5: acknowledge byte transmitted on each send_resp.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_rdy  input  1  UART receiver holds a valid byte; stays high until cleared.
- rx_data  input  8  received byte, valid while rx_rdy=1.
- clr_rx_rdy  output  1  combinational, high in the cycle a byte is consumed.
- cmd  output  16  assembled command {high, low}.
- cmd_rdy  output  1  cmd valid, held until clr_cmd_rdy.
- clr_cmd_rdy  input  1  consumer has taken cmd.
- send_resp  input  1  one-cycle request to send RESP_BYTE.
- trmt  output  1  registered one-cycle transmit strobe.
- tx_data  output  8  byte to transmit; constant RESP_BYTE.
- tx_done  input  1  one-cycle pulse when transmitter finishes a byte.
- resp_busy  output  1  a response is in flight or pending.
- overrun  output  1  one-cycle pulse: completed command dropped.
- timeout  output  1  one-cycle pulse: stale high byte discarded.

## Operation
- RX FSM, states WAIT_HIGH, WAIT_LOW. Reset to WAIT_HIGH.
- WAIT_HIGH: rx_rdy=1 → clr_rx_rdy=1, high_byte ← rx_data, clear timeout counter, go WAIT_LOW.
- WAIT_LOW: counter increments each cycle with rx_rdy=0. rx_rdy=1 → clr_rx_rdy=1, complete command, go WAIT_HIGH. Counter reaching TIMEOUT−1 with rx_rdy=0 → timeout pulse, discard high_byte, go WAIT_HIGH.
- Byte arriving on the timeout cycle wins: it is taken as the low byte, no timeout pulse.
- Completion: if cmd_rdy=0 or clr_cmd_rdy=1 this cycle → cmd ← {high_byte, rx_data}, cmd_rdy ← 1. Else cmd and cmd_rdy unchanged, overrun pulses next cycle.
- clr_cmd_rdy with no completion → cmd_rdy ← 0; cmd retains its value.
- TX FSM, states TX_IDLE, TX_WAIT; one-deep pending flag.
- TX_IDLE, send_resp=1 → trmt=1 next cycle, go TX_WAIT.
- TX_WAIT: send_resp=1 → pending ← 1 (already pending: request dropped). tx_done=1 and pending=1 → trmt=1 next cycle, pending ← 0, stay TX_WAIT. tx_done=1 and pending=0 → TX_IDLE.
- send_resp and tx_done in the same TX_WAIT cycle → current byte ends, new byte issued immediately (trmt next cycle), pending stays 0.
- resp_busy = (TX state ≠ TX_IDLE) | pending.
- RX and TX paths independent; no interaction.

## Timing
- Reset values: cmd=16'h0000, cmd_rdy=0, trmt=0, tx_data=RESP_BYTE, resp_busy=0, overrun=0, timeout=0; RX in WAIT_HIGH, TX in TX_IDLE, pending=0, counter=0.
- Reset mid-command discards high_byte; reset mid-transmit drops the pending request (transmitter not notified).
- clr_rx_rdy: combinational, same cycle as the rx_rdy it acknowledges; at most one byte consumed per cycle.
- cmd_rdy rises the cycle after the low byte is consumed; falls the cycle after clr_cmd_rdy.
- trmt rises one cycle after the accepted send_resp or tx_done; exactly one cycle wide.
- Timeout counter: 22 bits, saturating; cleared on entry to WAIT_LOW.
- overrun and timeout: registered, one cycle wide.

## Test plan
- Bytes 8'h23 then 8'h45 (gap 10 cycles) → clr_rx_rdy once per byte; cmd=16'h2345, cmd_rdy=1 the cycle after the 2nd byte; clr_cmd_rdy → cmd_rdy=0 next cycle, cmd still 16'h2345.
- TIMEOUT=16: byte 8'h23, 20-cycle idle, then 8'h00, 8'h00 → timeout pulses at cycle 15 after the first byte; cmd=16'h0000, never 16'h2300.
- cmd_rdy held (no clr); full pair 8'h40,8'h00 → overrun pulse, cmd unchanged; repeat with clr_cmd_rdy coincident with low byte → cmd=16'h4000, cmd_rdy stays 1, no overrun.
- send_resp pulse → trmt one cycle later, tx_data=8'hA5, resp_busy=1; tx_done 100 cycles later → resp_busy=0 next cycle.
- Three send_resp pulses during one transmission → exactly two trmt pulses total; second trmt one cycle after first tx_done.
- Assert rst between high and low byte, then send 8'h00,8'h01 → cmd=16'h0001 (old high byte lost), all outputs at reset values during rst.

Source files
------------

// File: rtl/cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module   : cmd_assembler
// Brief    : Pairs UART bytes (high first) into 16-bit commands with a ready
//            flag, resynchronizes on inter-byte timeout, and issues an
//            acknowledge byte to the UART transmitter on request.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_assembler #(
  parameter logic [21:0] TIMEOUT   = 22'd2_500_000,
  parameter logic [7:0]  RESP_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_busy,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic {WAIT_HIGH = 1'b0, WAIT_LOW = 1'b1} rx_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_WAIT = 1'b1} tx_state_t;

  // The counter is compared before it increments, so expiry is detected on the
  // cycle in which it would reach TIMEOUT-1.
  localparam logic [21:0] C_EXPIRE_AT = TIMEOUT - 22'd2;

  rx_state_t   r_rx_state, w_rx_next;
  logic        w_take_high, w_take_low, w_expire;
  logic [7:0]  r_high_byte;
  logic [21:0] r_count;

  tx_state_t   r_tx_state, w_tx_next;
  logic        r_pending, w_pending_next, w_trmt_next;

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= WAIT_HIGH;
    else     r_rx_state <= w_rx_next;
  end

  // RX next-state and byte-consume decode; a byte on the expiry cycle wins
  always_comb begin
    w_rx_next   = r_rx_state;
    clr_rx_rdy  = 1'b0;
    w_take_high = 1'b0;
    w_take_low  = 1'b0;
    w_expire    = 1'b0;
    case (r_rx_state)
      WAIT_HIGH: begin
        if (rx_rdy) begin
          clr_rx_rdy  = 1'b1;
          w_take_high = 1'b1;
          w_rx_next   = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          w_take_low = 1'b1;
          w_rx_next  = WAIT_HIGH;
        end else if (r_count == C_EXPIRE_AT) begin
          w_expire  = 1'b1;
          w_rx_next = WAIT_HIGH;
        end
      end
    endcase
  end

  // High-byte capture and saturating inter-byte idle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_high_byte <= 8'h00;
      r_count     <= 22'd0;
    end else if (w_take_high) begin
      r_high_byte <= rx_data;
      r_count     <= 22'd0;
    end else if (r_rx_state == WAIT_LOW && !rx_rdy && r_count != '1) begin
      r_count <= r_count + 22'd1;
    end
  end

  // Command hold register, ready flag and single-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= 16'h0000;
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= w_expire;
      if (w_take_low) begin
        if (!cmd_rdy || clr_cmd_rdy) begin
          cmd     <= {r_high_byte, rx_data};
          cmd_rdy <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  // TX state, pending flag and registered transmit strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_pending  <= 1'b0;
      trmt       <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_pending  <= w_pending_next;
      trmt       <= w_trmt_next;
    end
  end

  // TX next-state: one byte in flight plus at most one queued request
  always_comb begin
    w_tx_next      = r_tx_state;
    w_pending_next = r_pending;
    w_trmt_next    = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (send_resp) begin
          w_trmt_next = 1'b1;
          w_tx_next   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_done) begin
          if (r_pending) begin
            w_trmt_next    = 1'b1;
            w_pending_next = 1'b0;
          end else if (send_resp) begin
            w_trmt_next = 1'b1;
          end else begin
            w_tx_next = TX_IDLE;
          end
        end else if (send_resp) begin
          w_pending_next = 1'b1;
        end
      end
    endcase
  end

  assign resp_busy = (r_tx_state != TX_IDLE) | r_pending;
  assign tx_data   = RESP_BYTE;

endmodule
`default_nettype wire

// File: tb/tb_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_assembler
// Brief    : Directed scenarios plus random traffic for cmd_assembler, checked
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_assembler;

  localparam logic [21:0] TO = 22'd16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        resp_busy;
  logic        overrun;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model state
  logic        m_have_hi = 1'b0;
  logic [7:0]  m_hi = 8'h00;
  int          m_hi_cyc = 0;
  logic [15:0] m_cmd = 16'h0000;
  logic        m_cmd_rdy = 1'b0;
  logic        m_ovr = 1'b0;
  logic        m_to = 1'b0;
  logic        m_trmt = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_queued = 1'b0;

  always #5 clk = ~clk;

  cmd_assembler #(.TIMEOUT(TO), .RESP_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .trmt(trmt),
    .tx_data(tx_data), .tx_done(tx_done), .resp_busy(resp_busy),
    .overrun(overrun), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of the reference model, in terms of bytes, commands and requests
  task automatic model_cycle(input logic r, input logic rr, input logic [7:0] d,
                             input logic ccr, input logic sr, input logic td);
    logic completed;
    completed = 1'b0;
    m_ovr  = 1'b0;
    m_to   = 1'b0;
    m_trmt = 1'b0;
    if (r) begin
      m_have_hi = 1'b0; m_cmd = 16'h0000; m_cmd_rdy = 1'b0;
      m_busy = 1'b0; m_queued = 1'b0;
      return;
    end
    if (rr) begin
      if (!m_have_hi) begin
        m_have_hi = 1'b1; m_hi = d; m_hi_cyc = cyc;
      end else begin
        completed = 1'b1;
        m_have_hi = 1'b0;
        if (!m_cmd_rdy || ccr) begin
          m_cmd = {m_hi, d}; m_cmd_rdy = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end else if (m_have_hi && (cyc - m_hi_cyc) == int'(TO) - 1) begin
      m_to = 1'b1; m_have_hi = 1'b0;
    end
    if (ccr && !completed) m_cmd_rdy = 1'b0;
    if (!m_busy) begin
      if (sr) begin m_busy = 1'b1; m_trmt = 1'b1; end
    end else if (td) begin
      if (m_queued)  begin m_trmt = 1'b1; m_queued = 1'b0; end
      else if (sr)   m_trmt = 1'b1;
      else           m_busy = 1'b0;
    end else if (sr) begin
      m_queued = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, check the combinational ack, then registered outputs
  task automatic step(input logic r, input logic rr, input logic [7:0] d,
                      input logic ccr, input logic sr, input logic td);
    rst = r; rx_rdy = rr; rx_data = d; clr_cmd_rdy = ccr; send_resp = sr; tx_done = td;
    #1;
    if (!r) chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(rr));
    model_cycle(r, rr, d, ccr, sr, td);
    @(posedge clk);
    #1;
    chk("cmd", 32'(cmd), 32'(m_cmd));
    chk("cmd_rdy", 32'(cmd_rdy), 32'(m_cmd_rdy));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("trmt", 32'(trmt), 32'(m_trmt));
    chk("resp_busy", 32'(resp_busy), 32'(m_busy | m_queued));
    chk("tx_data", 32'(tx_data), 32'h0000_00A5);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic byte_in(input logic [7:0] d, input logic ccr);
    step(1'b0, 1'b1, d, ccr, 1'b0, 1'b0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ntr;
    bit sparse;

    // reset values
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_busy", 32'(resp_busy), 32'h0);

    // basic pair with a 10-cycle gap, then consumer clear
    byte_in(8'h23, 1'b0);
    idle(10);
    byte_in(8'h45, 1'b0);
    chk("pair_cmd", 32'(cmd), 32'h2345);
    chk("pair_rdy", 32'(cmd_rdy), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("clr_rdy", 32'(cmd_rdy), 32'h0);
    chk("clr_cmd_kept", 32'(cmd), 32'h2345);

    // inter-byte timeout discards the stale high byte
    byte_in(8'h23, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("to_pulse", 32'(timeout), 32'(i == 15));
    end
    byte_in(8'h00, 1'b0);
    byte_in(8'h00, 1'b0);
    chk("to_cmd", 32'(cmd), 32'h0000);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // overrun while cmd_rdy held, then clear coincident with low byte
    byte_in(8'h11, 1'b0);
    byte_in(8'h22, 1'b0);
    byte_in(8'h40, 1'b0);
    byte_in(8'h00, 1'b0);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_cmd", 32'(cmd), 32'h1122);
    byte_in(8'h40, 1'b0);
    byte_in(8'h00, 1'b1);
    chk("coinc_cmd", 32'(cmd), 32'h4000);
    chk("coinc_rdy", 32'(cmd_rdy), 32'h1);
    chk("coinc_ovr", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // single response with a long transmit
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("tx_trmt", 32'(trmt), 32'h1);
    chk("tx_busy", 32'(resp_busy), 32'h1);
    idle(99);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("tx_idle", 32'(resp_busy), 32'h0);

    // three requests during one transmission give exactly two strobes
    ntr = 0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); ntr += int'(trmt);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, (i == 2 || i == 5), 1'b0);
      ntr += int'(trmt);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); ntr += int'(trmt);
    chk("q_trmt_after_done", 32'(trmt), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); ntr += int'(trmt);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); ntr += int'(trmt);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); ntr += int'(trmt);
    end
    chk("q_trmt_count", 32'(ntr), 32'd2);
    chk("q_idle", 32'(resp_busy), 32'h0);

    // reset mid-command and mid-transmit
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    byte_in(8'h77, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_cmd", 32'(cmd), 32'h0);
    chk("mid_rst_busy", 32'(resp_busy), 32'h0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    byte_in(8'h00, 1'b0);
    byte_in(8'h01, 1'b0);
    chk("post_rst_cmd", 32'(cmd), 32'h0001);

    // random traffic with dense and sparse byte phases
    sparse = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) sparse = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 499) == 0),
           sparse ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 2) == 0),
           8'($urandom),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
